pipe_stage_skid: RTL

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_pkg.sv | 6 +
 rtl/pipe_skid_ctrl.sv | 63 ++++++
 rtl/pipe_stage_skid.sv | 60 ++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared skid-stage state encoding and default payload widths
package pipe_pkg;
    localparam int PIPE_DATA_W = 101;
    localparam int PIPE_CTRL_W = 7;
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} skid_state_t;
endpackage

// File: rtl/pipe_skid_ctrl.sv
// pipe_skid_ctrl: occupancy state machine, registered in_ready and payload load enables
module pipe_skid_ctrl
    import pipe_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic       out_ready,
    input  logic       flush,
    output logic       in_ready,
    output logic       out_valid,
    output logic       main_en,
    output logic       main_from_skid,
    output logic       skid_en,
    output logic [1:0] occupancy
);
    skid_state_t state, state_nxt;
    logic in_xfer, out_xfer;

    assign out_valid = state != EMPTY;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;
    assign occupancy = state;

    always_comb begin
        state_nxt      = state;
        main_en        = 1'b0;
        main_from_skid = 1'b0;
        skid_en        = 1'b0;
        if (!flush) begin
            case (state)
                EMPTY: begin
                    state_nxt = in_xfer ? ONE : EMPTY;
                    main_en   = in_xfer;
                end
                ONE: begin
                    state_nxt = in_xfer ? (out_xfer ? ONE : TWO) : (out_xfer ? EMPTY : ONE);
                    main_en   = in_xfer & out_xfer;
                    skid_en   = in_xfer & !out_xfer;
                end
                TWO: begin
                    state_nxt      = out_xfer ? ONE : TWO;
                    main_en        = out_xfer;
                    main_from_skid = out_xfer;
                end
                default: state_nxt = EMPTY;
            endcase
        end else begin
            state_nxt = EMPTY;
        end
    end

    // in_ready comes from the next state so out_ready never reaches it combinationally
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            in_ready <= state_nxt != TWO;
        end
    end
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: pipeline register stage with one-entry skid buffer and flush
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);
    logic [DATA_W-1:0] main_data, skid_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic main_en, main_from_skid, skid_en;

    pipe_skid_ctrl u_ctrl (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .out_ready     (out_ready),
        .flush         (flush),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .main_en       (main_en),
        .main_from_skid(main_from_skid),
        .skid_en       (skid_en),
        .occupancy     (occupancy)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else begin
            if (main_en) begin
                main_data <= main_from_skid ? skid_data : in_data;
                main_ctrl <= main_from_skid ? skid_ctrl : in_ctrl;
            end
            if (skid_en) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
            end
        end
    end

    // invalid slots present an all-zero control word so downstream sees a bubble
    assign out_data = main_data;
    assign out_ctrl = out_valid ? main_ctrl : '0;
endmodule
